// File: rtl/mem_pkg.sv
// mem_pkg: shared types and the byte-lane mask helper for the memory initiator.
package mem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
  typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1, RESP} state_t;
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    m = (size == SZ_B) ? 8'h01 : (size == SZ_H) ? 8'h03 : 8'h0f;
    return m << off;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane shifter and load extractor/extender over a two-word window.
module mem_align
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [63:0] wd64,
  output logic [7:0]  be8,
  output logic [31:0] rdata
);
  logic [31:0] rd;
  assign wd64 = {32'b0, wdata} << {off, 3'b0};
  assign be8  = byte_mask(size, off);
  assign rd   = 32'({hi, lo} >> {off, 3'b0});
  assign rdata = (size == SZ_B) ? {{24{~uns & rd[7]}}, rd[7:0]}
               : (size == SZ_H) ? {{16{~uns & rd[15]}}, rd[15:0]}
               : rd;
endmodule

// File: rtl/mem_master.sv
// mem_master: BRAM ready/valid initiator issuing one or two word beats per byte/half/word access.
module mem_master
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [31:0]           i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [3:0]            o_mem_byte_we,
  output logic                  o_mem_wr_valid,
  input  logic                  i_mem_wr_ready,
  output logic                  o_mem_rd_ready,
  input  logic                  i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);
  state_t state;
  size_t sz_q, sz_in, sz_al;
  logic [1:0] off_q, off_al;
  logic uns_q, uns_al, idle, accept, unused_addr;
  logic [ADDR_WIDTH-1:0] w0_q, w0_in, w1;
  logic [63:0] wd_q, wd64;
  logic [7:0] be_q, be8;
  logic [31:0] lo_q, lo_al, hi_al, rdata;
  assign unused_addr = ^i_req_addr[31:ADDR_WIDTH+2];
  assign w0_in  = i_req_addr[ADDR_WIDTH+1:2];
  assign w1     = w0_q + ADDR_WIDTH'(1);
  assign sz_in  = (i_req_size == 2'd3) ? SZ_W : size_t'(i_req_size);
  assign idle   = state == IDLE;
  assign accept = idle & i_req_valid & o_req_ready;
  // The aligner sees the live request in IDLE so beat 0 can be registered on accept.
  assign sz_al  = idle ? sz_in : sz_q;
  assign off_al = idle ? i_req_addr[1:0] : off_q;
  assign uns_al = idle ? i_req_unsigned : uns_q;
  assign lo_al  = (state == RD0) ? i_mem_data : lo_q;
  assign hi_al  = (state == RD1) ? i_mem_data : 32'b0;
  mem_align u_align (
    .size (sz_al),
    .off  (off_al),
    .uns  (uns_al),
    .wdata(i_req_wdata),
    .lo   (lo_al),
    .hi   (hi_al),
    .wd64 (wd64),
    .be8  (be8),
    .rdata(rdata)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      o_req_ready    <= 1'b1;
      o_resp_valid   <= 1'b0;
      o_resp_rdata   <= '0;
      o_mem_addr     <= '0;
      o_mem_data     <= '0;
      o_mem_byte_we  <= '0;
      o_mem_wr_valid <= 1'b0;
      o_mem_rd_ready <= 1'b0;
      sz_q           <= SZ_B;
      off_q          <= '0;
      uns_q          <= 1'b0;
      w0_q           <= '0;
      wd_q           <= '0;
      be_q           <= '0;
      lo_q           <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sz_q        <= sz_in;
          off_q       <= i_req_addr[1:0];
          uns_q       <= i_req_unsigned;
          w0_q        <= w0_in;
          wd_q        <= wd64;
          be_q        <= be8;
          o_req_ready <= 1'b0;
          o_mem_addr  <= w0_in;
          if (i_req_write) begin
            state          <= WR0;
            o_mem_data     <= wd64[31:0];
            o_mem_byte_we  <= be8[3:0];
            o_mem_wr_valid <= 1'b1;
          end else begin
            state          <= RD0;
            o_mem_rd_ready <= 1'b1;
          end
        end
        WR0: if (i_mem_wr_ready) begin
          if (|be_q[7:4]) begin
            state         <= WR1;
            o_mem_addr    <= w1;
            o_mem_data    <= wd_q[63:32];
            o_mem_byte_we <= be_q[7:4];
          end else begin
            state          <= RESP;
            o_mem_wr_valid <= 1'b0;
            o_mem_data     <= '0;
            o_mem_byte_we  <= '0;
            o_resp_valid   <= 1'b1;
          end
        end
        WR1: if (i_mem_wr_ready) begin
          state          <= RESP;
          o_mem_wr_valid <= 1'b0;
          o_mem_data     <= '0;
          o_mem_byte_we  <= '0;
          o_resp_valid   <= 1'b1;
        end
        RD0: if (i_mem_rd_valid) begin
          lo_q <= i_mem_data;
          if (|be_q[7:4]) begin
            state      <= RD1;
            o_mem_addr <= w1;
          end else begin
            state          <= RESP;
            o_mem_rd_ready <= 1'b0;
            o_resp_valid   <= 1'b1;
            o_resp_rdata   <= rdata;
          end
        end
        RD1: if (i_mem_rd_valid) begin
          state          <= RESP;
          o_mem_rd_ready <= 1'b0;
          o_resp_valid   <= 1'b1;
          o_resp_rdata   <= rdata;
        end
        RESP: begin
          state        <= IDLE;
          o_resp_valid <= 1'b0;
          o_resp_rdata <= '0;
          o_req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator side of the BRAM ready/valid memory interface; drives `bram_rv` from the core's load/store path.
- Accepts one byte/half/word load or store at a byte address and issues word-wide read/write beats.
- Splits any access that crosses a word boundary into two beats.
- Merges or shifts data, then returns one response per request.

Parameters:
DATA_WIDTH, 32, memory word width in bits; fixed at 32 for this revision.
ADDR_WIDTH, 8, memory word-address width; the byte address uses bits [ADDR_WIDTH+1:0], upper bits are ignored.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_req_valid  in  1  request strobe
o_req_ready  out  1  high only in IDLE
i_req_write  in  1  1 = store, 0 = load
i_req_addr  in  32  byte address
i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
i_req_unsigned  in  1  zero-extend load result
i_req_wdata  in  32  store data, right-aligned
o_resp_valid  out  1  one-cycle completion pulse (loads and stores)
o_resp_rdata  out  32  extended load data; 0 for stores
o_mem_addr  out  ADDR_WIDTH  word address
o_mem_data  out  32  write data, lane-shifted
o_mem_byte_we  out  4  byte enables; bit n = bits 8n+7:8n
o_mem_wr_valid  out  1  write strobe
i_mem_wr_ready  in  1  write accepted this cycle
o_mem_rd_ready  out  1  read request
i_mem_rd_valid  in  1  read data valid
i_mem_data  in  32  read data

Behaviour:
- Clock/reset: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: all outputs 0, except o_req_ready = 1 from the first cycle after reset. State = IDLE.
- Reset mid-operation: abort immediately. No response; strobes low next cycle.
- Byte order: little-endian; byte address offset `off` = addr[1:0] selects the lane.
- Request latch: in IDLE, i_req_valid & o_req_ready latches every request field.
- Beat masks: nbytes = 1/2/4; be8 = ((1<<nbytes)-1) << off (8 bits); wd64 = {32'b0, wdata} << 8*off.
- Beat addresses:
  - w0 = addr[ADDR_WIDTH+1:2].
  - w1 = w0+1 mod 2^ADDR_WIDTH, so the top word wraps to 0.
  - Second beat is needed iff be8[7:4] != 0.
- States:
  - IDLE: on accept, go to WR0 (store) or RD0 (load).
  - WR0: addr = w0, data = wd64[31:0], be = be8[3:0], wr_valid = 1. Hold all outputs stable until i_mem_wr_ready, then go to WR1 if a second beat is needed, else RESP.
  - WR1: addr = w1, data = wd64[63:32], be = be8[7:4]; same handshake, then RESP.
  - RD0: addr = w0, rd_ready = 1, address held constant. On i_mem_rd_valid, capture lo = i_mem_data, then go to RD1 or RESP.
  - RD1: same as RD0 with w1; capture hi.
  - RESP: o_resp_valid = 1 for exactly one cycle, then IDLE.
- Load result: ({hi, lo} >> 8*off), truncated to nbytes and sign- or zero-extended. hi = 0 when there is no second beat.
- Read handshake rules:
  - rd_ready is deasserted in the cycle after rd_valid is seen.
  - i_mem_rd_valid outside RD0/RD1 is ignored.
  - i_mem_wr_ready outside WR0/WR1 is ignored.
- o_mem_byte_we = 0 whenever wr_valid = 0.
- Latency, counted from the accept cycle = 0, with a zero-wait `bram_rv`:
  - aligned load: resp in cycle 3
  - split load: resp in cycle 5
  - aligned store: resp in cycle 2
  - split store: resp in cycle 3
- Back-to-back requests: the next request can be accepted the cycle after RESP.

Decomposition:
- Package mem_pkg:
  - size_t enum (SZ_B, SZ_H, SZ_W)
  - state_t enum (IDLE, WR0, WR1, RD0, RD1, RESP)
  - function byte_mask(size, off) returning 8 bits
- Sub-module mem_align: combinational store shifter (wd64/be8) and load extractor/extender. The FSM stays in mem_master.

Test Plan:
- All scenarios use `bram_rv` with DATA_WIDTH 32, ADDR_WIDTH 8 as the memory.
- Aligned word: SW 0x11223344 @0x100 -> one beat, be 4'b1111, word 0x40 = 0x11223344, resp at cycle 2. Then LW @0x100 -> rdata 0x11223344 at cycle 3.
- Sub-word: SB 0x31 @0x100, SB 0x32 @0x101, SH 0x3433 @0x102, then:
  - LBU @0x102 -> 0x00000033
  - LHU @0x100 -> 0x00003231
  - SB 0x80 @0x104, then LB @0x104 -> 0xFFFFFF80
- Split store/load: SW 0xAABBCCDD @0x103 -> beats (0x40, be 4'b1000, byte3 = DD) then (0x41, be 4'b0111, low bytes CC, BB, AA). LW @0x103 -> 0xAABBCCDD at cycle 5.
- Wrap: LH @0x3FF with word 0xFF byte3 = 0x12 and word 0x00 byte0 = 0x34 -> reads word 0xFF then word 0x00; rdata 0x00003412.
- Stall/spurious: hold i_mem_wr_ready = 0 for 3 cycles in WR0 -> addr/data/be stable, no resp. Pulse i_mem_rd_valid in IDLE -> no state change, no resp.
- Reset mid-op: assert i_rst during RD1 of a split LW -> no o_resp_valid, all strobes 0 next cycle, o_req_ready = 1. A following aligned LW completes normally.
